// File: rtl/nav_pkg.sv
// Shared types and default constants for the navigation speed profiler.
package nav_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEAD   = 3'd1,
        ACCL   = 3'd2,
        CRUISE = 3'd3,
        DECN   = 3'd4,
        DECF   = 3'd5
    } nav_state_t;

    localparam int DEF_SPD_W    = 11;
    localparam int DEF_SKIP_W   = 3;
    localparam int DEF_MAX_SPD  = 'h2A0;
    localparam int DEF_MIN_SPD  = 'h0D0;
    localparam int DEF_HDNG_TMO = 1024;

    // Speed step per hdng_rdy; the large step shortens simulated ramps.
    function automatic int inc_for(input int fast_sim);
        return (fast_sim != 0) ? 24 : 2;
    endfunction

endpackage

// File: rtl/nav_profile_if.sv
// Command, sensor and status bundle between the navigation controller and nav_profile.
interface nav_profile_if import nav_pkg::*; #(
    parameter int SPD_W  = DEF_SPD_W,
    parameter int SKIP_W = DEF_SKIP_W
);
    // Handshake: command and sensor inputs are sampled on every rising clock edge
    // (pulses need only be high for that one edge); mv_cmplt is the completion
    // valid, a single-cycle pulse qualified by mv_err, with no ready: the consumer
    // must take it in the cycle it is presented.
    logic              strt_hdng;
    logic              strt_mv;
    logic              stp_lft;
    logic              stp_rght;
    logic              abort;
    logic [SKIP_W-1:0] skip_cnt;
    logic              hdng_rdy;
    logic              at_hdng;
    logic              lft_opn;
    logic              rght_opn;
    logic              frwrd_opn;
    logic              mv_cmplt;
    logic              mv_err;
    logic              moving;
    logic              en_fusion;
    logic [SPD_W-1:0]  frwrd_spd;

    modport master (
        output strt_hdng, strt_mv, stp_lft, stp_rght, abort, skip_cnt,
        output hdng_rdy, at_hdng, lft_opn, rght_opn, frwrd_opn,
        input  mv_cmplt, mv_err, moving, en_fusion, frwrd_spd
    );

    modport slave (
        input  strt_hdng, strt_mv, stp_lft, stp_rght, abort, skip_cnt,
        input  hdng_rdy, at_hdng, lft_opn, rght_opn, frwrd_opn,
        output mv_cmplt, mv_err, moving, en_fusion, frwrd_spd
    );

endinterface

// File: rtl/opn_edge_det.sv
// Rising-edge detector for a wall-opening sensor, gated so only enabled edges report.
module opn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl_i,
    input  logic en_i,
    output logic rise_o
);

    logic lvl_q;

    // Resetting high stops an opening already present at reset from looking new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b1;
        end else begin
            lvl_q <= lvl_i;
        end
    end

    assign rise_o = en_i & lvl_i & ~lvl_q;

endmodule

// File: rtl/nav_profile.sv
// Forward speed profiler: heading phase, accelerate/cruise, and normal or fast deceleration.
module nav_profile import nav_pkg::*; #(
    parameter int FAST_SIM = 1,
    parameter int SPD_W    = DEF_SPD_W,
    parameter int MAX_SPD  = DEF_MAX_SPD,
    parameter int MIN_SPD  = DEF_MIN_SPD,
    parameter int SKIP_W   = DEF_SKIP_W,
    parameter int HDNG_TMO = DEF_HDNG_TMO
) (
    input  logic          clk,
    input  logic          rst_n,
    nav_profile_if.slave  bus,
    output nav_state_t    state_o
);

    localparam int INC   = inc_for(FAST_SIM);
    localparam int TMO_W = $clog2(HDNG_TMO + 1);

    localparam logic [SPD_W-1:0] MAX_L  = SPD_W'(MAX_SPD);
    localparam logic [SPD_W-1:0] MIN_L  = SPD_W'(MIN_SPD);
    localparam logic [SPD_W-1:0] INC_L  = SPD_W'(INC);
    localparam logic [SPD_W-1:0] DECN_L = SPD_W'(2 * INC);
    localparam logic [SPD_W-1:0] DECF_L = SPD_W'(8 * INC);
    localparam logic [SPD_W-1:0] FUS_L  = SPD_W'(MAX_SPD / 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HDNG_TMO - 1);

    nav_state_t        state_q, state_d;
    logic [SPD_W-1:0]  spd_q, spd_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              abrt_q, abrt_d;
    logic              cmplt_q, cmplt_d;
    logic              err_q, err_d;

    logic              edge_en;
    logic              lft_rise;
    logic              rght_rise;
    logic              opening;
    logic [SPD_W:0]    spd_sum;
    logic [SPD_W-1:0]  spd_acc;
    logic [SPD_W-1:0]  spd_decn;
    logic [SPD_W-1:0]  spd_decf;

    assign edge_en = (state_q == ACCL) || (state_q == CRUISE);

    opn_edge_det u_lft_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (bus.lft_opn),
        .en_i   (edge_en),
        .rise_o (lft_rise)
    );

    opn_edge_det u_rght_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (bus.rght_opn),
        .en_i   (edge_en),
        .rise_o (rght_rise)
    );

    // Left and right edges in the same cycle collapse into a single opening.
    assign opening = (lft_rise & bus.stp_lft) | (rght_rise & bus.stp_rght);

    // One extra bit on the sum so saturation sees the true overflow.
    assign spd_sum  = {1'b0, spd_q} + {1'b0, INC_L};
    assign spd_acc  = (spd_sum > {1'b0, MAX_L}) ? MAX_L : spd_sum[SPD_W-1:0];
    assign spd_decn = (spd_q > DECN_L) ? (spd_q - DECN_L) : '0;
    assign spd_decf = (spd_q > DECF_L) ? (spd_q - DECF_L) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            spd_q   <= '0;
            skip_q  <= '0;
            tmo_q   <= '0;
            abrt_q  <= 1'b0;
            cmplt_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            spd_q   <= spd_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            abrt_q  <= abrt_d;
            cmplt_q <= cmplt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        spd_d   = spd_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        abrt_d  = abrt_q;
        cmplt_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.strt_mv) begin
                    spd_d   = MIN_L;
                    skip_d  = bus.skip_cnt;
                    abrt_d  = 1'b0;
                    state_d = ACCL;
                end else if (bus.strt_hdng) begin
                    tmo_d   = '0;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (bus.at_hdng) begin
                    cmplt_d = 1'b1;
                    state_d = IDLE;
                end else if (bus.abort) begin
                    cmplt_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bus.hdng_rdy) begin
                    if (tmo_q == TMO_LAST) begin
                        cmplt_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            ACCL, CRUISE: begin
                if (state_q == ACCL) begin
                    if (bus.hdng_rdy) spd_d = spd_acc;
                    if (spd_q == MAX_L) state_d = CRUISE;
                end
                // Loss of the forward path or an abort overrides everything else.
                if (bus.abort || !bus.frwrd_opn) begin
                    spd_d   = spd_q;
                    abrt_d  = bus.abort;
                    state_d = DECF;
                end else if (opening) begin
                    if (skip_q == '0) state_d = DECN;
                    else              skip_d  = skip_q - SKIP_W'(1);
                end
            end
            DECN: begin
                if (bus.abort || !bus.frwrd_opn) begin
                    abrt_d  = bus.abort;
                    state_d = DECF;
                end else if (spd_q == '0) begin
                    cmplt_d = 1'b1;
                    err_d   = abrt_q;
                    state_d = IDLE;
                end else if (bus.hdng_rdy) begin
                    spd_d = spd_decn;
                end
            end
            DECF: begin
                if (spd_q == '0) begin
                    cmplt_d = 1'b1;
                    err_d   = abrt_q;
                    state_d = IDLE;
                end else if (bus.hdng_rdy) begin
                    spd_d = spd_decf;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.frwrd_spd = spd_q;
    assign bus.mv_cmplt  = cmplt_q;
    assign bus.mv_err    = err_q;
    assign bus.moving    = (state_q != IDLE);
    assign bus.en_fusion = (spd_q > FUS_L);
    assign state_o       = state_q;

endmodule
